// File: rtl/processor_pkg.sv
// Shared opcodes, widths and the default program for the 8-bit accumulator processor.
package processor_pkg;

    localparam int DATA_W     = 8;
    localparam int PC_W       = 5;
    localparam int OPC_W      = 4;
    localparam int PROG_DEPTH = 32;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_STA  = 4'h2,
        OP_LDA  = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_NOT  = 4'h9,
        OP_SHL  = 4'hA,
        OP_SHR  = 4'hB,
        OP_JMP  = 4'hC,
        OP_JZ   = 4'hD,
        OP_HLT  = 4'hE,
        OP_SRST = 4'hF
    } opcode_t;

    // Element 0 is the least significant byte: LDI 5, STA R0, LDI 3, STA R1, LDA R0, ADD R1, HLT.
    localparam logic [PROG_DEPTH-1:0][DATA_W-1:0] DEFAULT_PROG = {
        {25{8'h00}}, 8'hE0, 8'h41, 8'h30, 8'h21, 8'h13, 8'h20, 8'h15
    };

    // Jump targets can only reach the lower half of program memory.
    function automatic logic [PC_W-1:0] jump_target(input logic [3:0] operand);
        return {1'b0, operand};
    endfunction

endpackage

// File: rtl/processor_alu.sv
// Purely combinational 8-bit ALU; b carries the immediate for LDI and Rn otherwise.
module alu
    import processor_pkg::*;
(
    input  opcode_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    // Result for the current opcode; non-ALU opcodes pass the accumulator through.
    always_comb begin
        result = a;
        case (op)
            OP_LDI, OP_LDA: result = b;
            OP_ADD:         result = a + b;
            OP_SUB:         result = a - b;
            OP_AND:         result = a & b;
            OP_OR:          result = a | b;
            OP_XOR:         result = a ^ b;
            OP_NOT:         result = ~a;
            OP_SHL:         result = {a[DATA_W-2:0], 1'b0};
            OP_SHR:         result = {1'b0, a[DATA_W-1:1]};
            default:        result = a;
        endcase
    end

endmodule

// File: rtl/processor.sv
// Single-cycle accumulator processor: ROM fetch, decode, R0/R1/ACU, PC and halt flag.
module processor
    import processor_pkg::*;
#(
    parameter logic [PROG_DEPTH-1:0][DATA_W-1:0] PROG = DEFAULT_PROG
) (
    input  logic              clk,
    input  logic              rstn_ext,
    output logic [PC_W-1:0]   prog_cnt_dbg,
    output logic              rstn_inter_dbg,
    output logic              load_en_dbg,
    output logic              store_en_dbg,
    output logic              R0_ce_dbg,
    output logic              R1_ce_dbg,
    output logic              R0_oe_dbg,
    output logic              R1_oe_dbg,
    output logic [DATA_W-1:0] R0_dbg,
    output logic [DATA_W-1:0] R1_dbg,
    output logic [DATA_W-1:0] ACU_dbg,
    output logic [DATA_W-1:0] reg_file_dbg,
    output logic [DATA_W-1:0] alu_result_dbg,
    output logic [OPC_W-1:0]  instr_code_dbg,
    output logic [DATA_W-1:0] prog_mem_data_dbg
);

    logic [PC_W-1:0]   pc, pc_next;
    logic [DATA_W-1:0] acu, r0, r1;
    logic              halted;
    logic [DATA_W-1:0] instr;
    opcode_t           op;
    logic [3:0]        operand;
    logic [DATA_W-1:0] rn_val, alu_b, alu_res, reg_bus;
    logic              load_en, store_en, r0_ce, r1_ce, r0_oe, r1_oe, sw_rst;

    assign instr   = PROG[pc];
    assign op      = opcode_t'(instr[7:4]);
    assign operand = instr[3:0];
    assign rn_val  = operand[0] ? r1 : r0;
    assign alu_b   = (op == OP_LDI) ? {4'b0000, operand} : rn_val;
    assign reg_bus = r0_oe ? r0 : (r1_oe ? r1 : '0);

    alu u_alu (
        .op     (op),
        .a      (acu),
        .b      (alu_b),
        .result (alu_res)
    );

    // Decode the current instruction into enables, software reset and next PC.
    always_comb begin
        load_en  = 1'b0;
        store_en = 1'b0;
        r0_ce    = 1'b0;
        r1_ce    = 1'b0;
        r0_oe    = 1'b0;
        r1_oe    = 1'b0;
        sw_rst   = 1'b0;
        pc_next  = pc + PC_W'(1);
        case (op)
            OP_LDI, OP_NOT, OP_SHL, OP_SHR: load_en = 1'b1;
            OP_STA: begin
                store_en = 1'b1;
                r0_ce    = ~operand[0];
                r1_ce    = operand[0];
            end
            OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                load_en = 1'b1;
                r0_oe   = ~operand[0];
                r1_oe   = operand[0];
            end
            OP_JMP:  pc_next = jump_target(operand);
            OP_JZ:   if (acu == '0) pc_next = jump_target(operand);
            OP_HLT:  pc_next = pc;
            OP_SRST: sw_rst = 1'b1;
            default: ;
        endcase
    end

    // Architectural state; software reset clears synchronously, halt freezes everything.
    always_ff @(posedge clk or posedge rstn_ext) begin
        if (rstn_ext) begin
            pc     <= '0;
            acu    <= '0;
            r0     <= '0;
            r1     <= '0;
            halted <= 1'b0;
        end else if (sw_rst) begin
            pc     <= '0;
            acu    <= '0;
            r0     <= '0;
            r1     <= '0;
            halted <= 1'b0;
        end else if (!halted) begin
            pc <= pc_next;
            if (load_en) acu <= alu_res;
            if (r0_ce)   r0  <= acu;
            if (r1_ce)   r1  <= acu;
            if (op == OP_HLT) halted <= 1'b1;
        end
    end

    assign prog_cnt_dbg      = pc;
    assign rstn_inter_dbg    = ~(rstn_ext | sw_rst);
    assign load_en_dbg       = load_en;
    assign store_en_dbg      = store_en;
    assign R0_ce_dbg         = r0_ce;
    assign R1_ce_dbg         = r1_ce;
    assign R0_oe_dbg         = r0_oe;
    assign R1_oe_dbg         = r1_oe;
    assign R0_dbg            = r0;
    assign R1_dbg            = r1;
    assign ACU_dbg           = acu;
    assign reg_file_dbg      = reg_bus;
    assign alu_result_dbg    = alu_res;
    assign instr_code_dbg    = instr[7:4];
    assign prog_mem_data_dbg = instr;

endmodule

// File: tb/tb_processor.sv
// Bench for processor: four instances with different ROMs, a behavioural model and literal checks.
module tb_processor;

    localparam int N = 4;

    localparam logic [31:0][7:0] ROM_DEF = {
        {25{8'h00}}, 8'hE0, 8'h41, 8'h30, 8'h21, 8'h13, 8'h20, 8'h15
    };
    // 0 LDI1,1 STA R0,2 JMP12,3 SUB R0,4 STA R1,5 XOR R0,6 SHR,7 SHL,8 OR R1,9 AND R0,
    // 10 JZ15 (not taken),11 HLT,12 LDI0,13 NOT,14 ADD R0,15 JZ3 (taken)
    localparam logic [31:0][7:0] ROM_ALU = {
        {16{8'h00}}, 8'hD3, 8'h40, 8'h90, 8'h10, 8'hE0, 8'hDF, 8'h60, 8'h71,
        8'hA0, 8'hB0, 8'h80, 8'h21, 8'h50, 8'hCC, 8'h20, 8'h11
    };
    localparam logic [31:0][7:0] ROM_NOP  = '0;
    localparam logic [31:0][7:0] ROM_SRST = {{27{8'h00}}, 8'hF0, {4{8'h00}}};
    localparam logic [N-1:0][31:0][7:0] ROMS = {ROM_SRST, ROM_NOP, ROM_ALU, ROM_DEF};

    logic clk = 1'b0;
    logic rst [N];

    logic [4:0] d_pc [N];
    logic       d_rsti [N], d_ld [N], d_st [N], d_c0 [N], d_c1 [N], d_o0 [N], d_o1 [N];
    logic [7:0] d_r0 [N], d_r1 [N], d_acu [N], d_bus [N], d_alu [N], d_pm [N];
    logic [3:0] d_ic [N];

    int total = 0;
    int bad   = 0;
    int ecount = 0;

    always #5 clk = ~clk;

    // Instance 0 relies on the package default program; the others get bench ROMs.
    for (genvar g = 0; g < N; g++) begin : g_dut
        if (g == 0) begin : g_def
            processor u_dut (
                .clk(clk), .rstn_ext(rst[g]), .prog_cnt_dbg(d_pc[g]), .rstn_inter_dbg(d_rsti[g]),
                .load_en_dbg(d_ld[g]), .store_en_dbg(d_st[g]), .R0_ce_dbg(d_c0[g]), .R1_ce_dbg(d_c1[g]),
                .R0_oe_dbg(d_o0[g]), .R1_oe_dbg(d_o1[g]), .R0_dbg(d_r0[g]), .R1_dbg(d_r1[g]),
                .ACU_dbg(d_acu[g]), .reg_file_dbg(d_bus[g]), .alu_result_dbg(d_alu[g]),
                .instr_code_dbg(d_ic[g]), .prog_mem_data_dbg(d_pm[g])
            );
        end else begin : g_rom
            processor #(.PROG(ROMS[g])) u_dut (
                .clk(clk), .rstn_ext(rst[g]), .prog_cnt_dbg(d_pc[g]), .rstn_inter_dbg(d_rsti[g]),
                .load_en_dbg(d_ld[g]), .store_en_dbg(d_st[g]), .R0_ce_dbg(d_c0[g]), .R1_ce_dbg(d_c1[g]),
                .R0_oe_dbg(d_o0[g]), .R1_oe_dbg(d_o1[g]), .R0_dbg(d_r0[g]), .R1_dbg(d_r1[g]),
                .ACU_dbg(d_acu[g]), .reg_file_dbg(d_bus[g]), .alu_result_dbg(d_alu[g]),
                .instr_code_dbg(d_ic[g]), .prog_mem_data_dbg(d_pm[g])
            );
        end
    end

    typedef struct packed {
        logic       ld, st, c0, c1, o0, o1;
        logic [7:0] bus, alu;
    } exp_t;

    int m_pc [N], m_acu [N], m_r0 [N], m_r1 [N];
    bit m_halt [N];

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    // Expected combinational outputs from the instruction semantics.
    function automatic exp_t model_outs(input logic [7:0] w, input int acu, input int r0, input int r1);
        exp_t e;
        int   op, rv, res;
        op  = int'(w[7:4]);
        rv  = w[0] ? r1 : r0;
        e   = '0;
        res = acu;
        case (op)
            1: begin e.ld = 1'b1; res = int'(w[3:0]); end
            2: begin e.st = 1'b1; e.c0 = !w[0]; e.c1 = w[0]; end
            3, 4, 5, 6, 7, 8: begin
                e.ld  = 1'b1;
                e.o0  = !w[0];
                e.o1  = w[0];
                e.bus = 8'(rv);
                case (op)
                    3: res = rv;
                    4: res = (acu + rv) % 256;
                    5: res = (acu - rv + 256) % 256;
                    6: res = acu & rv;
                    7: res = acu | rv;
                    default: res = acu ^ rv;
                endcase
            end
            9:  begin e.ld = 1'b1; res = 255 - acu; end
            10: begin e.ld = 1'b1; res = (acu * 2) % 256; end
            11: begin e.ld = 1'b1; res = acu / 2; end
            default: ;
        endcase
        e.alu = 8'(res);
        return e;
    endfunction

    always @(posedge clk) ecount <= ecount + 1;

    // Model state advance, one instruction per edge.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            logic [7:0] w;
            exp_t       e;
            int         op, old_acu;
            if (rst[i]) begin
                m_pc[i] = 0; m_acu[i] = 0; m_r0[i] = 0; m_r1[i] = 0; m_halt[i] = 0;
            end else if (!m_halt[i]) begin
                w       = ROMS[i][m_pc[i]];
                op      = int'(w[7:4]);
                e       = model_outs(w, m_acu[i], m_r0[i], m_r1[i]);
                old_acu = m_acu[i];
                if (op == 15) begin
                    m_pc[i] = 0; m_acu[i] = 0; m_r0[i] = 0; m_r1[i] = 0;
                end else begin
                    if (e.ld) m_acu[i] = int'(e.alu);
                    if (e.c0) m_r0[i] = old_acu;
                    if (e.c1) m_r1[i] = old_acu;
                    if (op == 12)                       m_pc[i] = int'(w[3:0]);
                    else if (op == 13 && old_acu == 0)  m_pc[i] = int'(w[3:0]);
                    else if (op == 14)                  m_halt[i] = 1;
                    else                                m_pc[i] = (m_pc[i] + 1) % 32;
                end
            end
        end
    end

    // Every cycle: all outputs of every instance against the model.
    always begin
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            logic [7:0] w;
            exp_t       e;
            w = ROMS[i][m_pc[i]];
            e = model_outs(w, m_acu[i], m_r0[i], m_r1[i]);
            chk("pc",    i, int'(d_pc[i]),  m_pc[i]);
            chk("acu",   i, int'(d_acu[i]), m_acu[i]);
            chk("r0",    i, int'(d_r0[i]),  m_r0[i]);
            chk("r1",    i, int'(d_r1[i]),  m_r1[i]);
            chk("pmem",  i, int'(d_pm[i]),  int'(w));
            chk("icode", i, int'(d_ic[i]),  int'(w[7:4]));
            chk("rsti",  i, int'(d_rsti[i]), (rst[i] || w[7:4] == 4'hF) ? 0 : 1);
            chk("ld",    i, int'(d_ld[i]),  int'(e.ld));
            chk("st",    i, int'(d_st[i]),  int'(e.st));
            chk("c0",    i, int'(d_c0[i]),  int'(e.c0));
            chk("c1",    i, int'(d_c1[i]),  int'(e.c1));
            chk("o0",    i, int'(d_o0[i]),  int'(e.o0));
            chk("o1",    i, int'(d_o1[i]),  int'(e.o1));
            chk("bus",   i, int'(d_bus[i]), int'(e.bus));
            chk("alu",   i, int'(d_alu[i]), int'(e.alu));
        end
    end

    task automatic wait_edge(input int n);
        while (ecount < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Directed sequence with hand-computed literal expectations.
    initial begin
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b1;
            m_pc[i] = 0; m_acu[i] = 0; m_r0[i] = 0; m_r1[i] = 0; m_halt[i] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #3;
        chk("rst_pc",   0, int'(d_pc[0]),   0);
        chk("rst_acu",  0, int'(d_acu[0]),  0);
        chk("rst_r0",   0, int'(d_r0[0]),   0);
        chk("rst_r1",   0, int'(d_r1[0]),   0);
        chk("rst_rsti", 0, int'(d_rsti[0]), 0);
        chk("rst_pmem", 0, int'(d_pm[0]),   8'h15);
        for (int i = 0; i < N; i++) rst[i] = 1'b0;
        ecount = 0;

        wait_edge(4);
        chk("srst_pc4",   3, int'(d_pc[3]),   4);
        chk("srst_rsti",  3, int'(d_rsti[3]), 0);
        chk("nop_pc4",    2, int'(d_pc[2]),   4);
        wait_edge(5);
        chk("add_o1",     0, int'(d_o1[0]),   1);
        chk("add_ld",     0, int'(d_ld[0]),   1);
        chk("add_bus",    0, int'(d_bus[0]),  3);
        chk("add_alu",    0, int'(d_alu[0]),  8);
        chk("srst_pc0",   3, int'(d_pc[3]),   0);
        wait_edge(6);
        chk("def_r0",     0, int'(d_r0[0]),   5);
        chk("def_r1",     0, int'(d_r1[0]),   3);
        chk("def_acu",    0, int'(d_acu[0]),  8);
        chk("def_pc",     0, int'(d_pc[0]),   6);
        chk("def_icode",  0, int'(d_ic[0]),   4'hE);
        chk("wrapadd",    1, int'(d_acu[1]),  0);
        wait_edge(7);
        chk("jz_pc",      1, int'(d_pc[1]),   3);
        wait_edge(8);
        chk("sub_acu",    1, int'(d_acu[1]),  8'hFF);

        @(negedge clk);
        #3;
        rst[2] = 1'b1;
        #1;
        chk("async_pc",   2, int'(d_pc[2]),   0);
        chk("async_rsti", 2, int'(d_rsti[2]), 0);
        @(negedge clk);
        #3;
        rst[2] = 1'b0;

        wait_edge(16);
        chk("alu_acu",    1, int'(d_acu[1]),  8'h01);
        chk("alu_r0",     1, int'(d_r0[1]),   8'h01);
        chk("alu_r1",     1, int'(d_r1[1]),   8'hFF);
        chk("alu_pc",     1, int'(d_pc[1]),   11);
        wait_edge(26);
        chk("hlt_pc",     0, int'(d_pc[0]),   6);
        chk("hlt_acu",    0, int'(d_acu[0]),  8);
        chk("hlt_r0",     0, int'(d_r0[0]),   5);
        chk("hlt_r1",     0, int'(d_r1[0]),   3);
        wait_edge(40);
        chk("nop_pc31",   2, int'(d_pc[2]),   31);
        wait_edge(41);
        chk("nop_wrap",   2, int'(d_pc[2]),   0);
        wait_edge(44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rstn_ext  input  1  asynchronous, active-high reset (1 = reset asserted), despite the name.
REQ-003 prog_cnt_dbg  output  5  current program counter.
REQ-004 rstn_inter_dbg  output  1  internal active-low reset = NOT(rstn_ext OR sw_rst).
REQ-005 load_en_dbg / store_en_dbg  output  1 each  ACU write enable / register-file write enable, decoded from current instruction.
REQ-006 R0_ce_dbg, R1_ce_dbg  output  1 each  R0/R1 write (chip) enables.
REQ-007 R0_oe_dbg, R1_oe_dbg  output  1 each  R0/R1 output enables onto the register-file bus.
REQ-008 R0_dbg, R1_dbg, ACU_dbg  output  8 each  register contents.
REQ-009 reg_file_dbg  output  8  register-file bus: R0 if R0_oe, R1 if R1_oe, else 0.
REQ-010 alu_result_dbg  output  8  combinational ALU result.
REQ-011 instr_code_dbg  output  4  opcode = prog_mem_data[7:4].
REQ-012 prog_mem_data_dbg  output  8  program ROM word at PC (combinational read).

Function
REQ-013 Program ROM: 32 x 8, read-only, contents = package constant DEFAULT_PROG; word = {opcode[3:0], operand[3:0]}.
REQ-014 Single-cycle execution: instruction at PC executes at the next rising edge; PC then increments by 1, wrapping 31 -> 0.
REQ-015 Register operand n = operand[0] (0 = R0, 1 = R1); operand[3:1] ignored.
REQ-016 0x0 NOP: no state change except PC.
REQ-017 0x1 LDI: ACU <= {4'b0, operand}; load_en=1.
REQ-018 0x2 STA: Rn <= ACU; store_en=1, Rn_ce=1.
REQ-019 0x3 LDA: ACU <= Rn; Rn_oe=1, load_en=1.
REQ-020 0x4 ADD / 0x5 SUB / 0x6 AND / 0x7 OR / 0x8 XOR: ACU <= ACU op Rn; Rn_oe=1, load_en=1; add/sub modulo 256, carry/borrow discarded.
REQ-021 0x9 NOT: ACU <= ~ACU; 0xA SHL: ACU <= ACU<<1 (LSB 0); 0xB SHR: ACU <= ACU>>1 (MSB 0); load_en=1.
REQ-022 0xC JMP: PC <= {1'b0, operand}.
REQ-023 0xD JZ: if ACU == 0 then PC <= {1'b0, operand}, else PC+1.
REQ-024 0xE HLT: PC holds; all state frozen until reset.
REQ-025 0xF SRST: sw_rst=1 for that cycle; rstn_inter_dbg low combinationally; next edge clears all state as in REQ-028.
REQ-026 All enable outputs 0 for opcodes not listing them; at most one of R0_oe/R1_oe and at most one of R0_ce/R1_ce asserted.
REQ-027 alu_result_dbg always reflects opcode applied to current ACU and Rn (pass-through of operand/Rn for LDI/LDA, ACU otherwise).

Reset
REQ-028 While rstn_ext=1: PC, ACU, R0, R1 = 0, halt flag cleared, rstn_inter_dbg = 0; effect immediate (asynchronous).
REQ-029 Reset deassertion synchronous-safe: first instruction (ROM[0]) executes at first rising edge with rstn_ext=0; reset mid-program aborts the current instruction.

Structure
REQ-030 Package processor_pkg: opcode constants, widths (DATA_W=8, PC_W=5), DEFAULT_PROG array.
REQ-031 One sub-module alu (8-bit, opcode + two operands in, result out, purely combinational); decode, registers, PC, ROM in top.

Verification
REQ-032 DEFAULT_PROG = 0x15,0x20,0x13,0x21,0x30,0x41,0xE0, rest 0x00.
REQ-033 Hold rstn_ext=1 two cycles -> PC=0, ACU=R0=R1=0, rstn_inter_dbg=0, prog_mem_data_dbg=0x15.
REQ-034 Release reset, run 6 cycles -> R0=5, R1=3, ACU=8, PC=6, instr_code_dbg=0xE; 20 further cycles -> PC stays 6, values unchanged.
REQ-035 During cycle PC=5 (ADD R1) -> R1_oe_dbg=1, load_en_dbg=1, reg_file_dbg=3, alu_result_dbg=8.
REQ-036 ROM with ACU=0xFF then ADD of R=0x01 -> ACU=0x00; following JZ 0x3 -> PC=3; SUB 0x00-0x01 -> 0xFF.
REQ-037 ROM of all NOP -> PC counts 0..31 then wraps to 0; assert rstn_ext mid-count -> PC=0 immediately; SRST (0xF0) at PC=4 -> rstn_inter_dbg=0 that cycle, PC=0 next.
